// File: rtl/pd_pkg.sv
// Shared definitions for the I-PD actuator path.
// Holds the system control-word width, the DAC frame width, the default DAC
// command nibble and the state encoding of the SPI frame sequencer.
package pd_pkg;

   // System control-word width shared with the I-PD controller
   localparam int PD_W = 19;

   // One SPI write-and-update frame: 4-bit command + 12-bit code
   localparam int FRAME_W = 16;

   // Default DAC command nibble: write input register and update output
   localparam logic [3:0] CMD_DEFAULT = 4'b0011;

   // Frame sequencer states
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_HOLD  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

endpackage

// File: rtl/dac_spi_driver_if.sv
// Controller-to-DAC driver bus.
//   u       signed control word from the controller
//   Listo   one-cycle strobe, u valid
//   SCLK    SPI clock (idles low)
//   MOSI    SPI data, MSB first
//   CS_n    active-low DAC chip select (SYNC)
//   Busy    frame or post-frame gap in progress
//   Hecho   one-cycle frame-complete pulse
//   Sat     code of the current/last frame was clamped
//   Overrun sticky, pending sample was overwritten
// master: controller side, slave: driver side.
interface dac_spi_driver_if
   import pd_pkg::*;
#(
   parameter int W = PD_W
);
   logic signed [W-1:0] u;
   logic                Listo;
   logic                SCLK;
   logic                MOSI;
   logic                CS_n;
   logic                Busy;
   logic                Hecho;
   logic                Sat;
   logic                Overrun;

   modport master (
      output u, Listo,
      input  SCLK, MOSI, CS_n, Busy, Hecho, Sat, Overrun
   );

   modport slave (
      input  u, Listo,
      output SCLK, MOSI, CS_n, Busy, Hecho, Sat, Overrun
   );
endinterface

// File: rtl/saturador_dac.sv
// Combinational control-word to DAC-code conversion.
// Arithmetic right shift by SHIFT, clamp to the signed N_DAC-bit range,
// then convert to offset binary by inverting the MSB.
//   u_i     signed W-bit input word
//   code_o  N_DAC-bit offset-binary DAC code
//   sat_o   high when the shifted value had to be clamped
module saturador_dac #(
   parameter int W     = 19,
   parameter int SHIFT = 4,
   parameter int N_DAC = 12
) (
   input  logic signed [W-1:0]     u_i,
   output logic        [N_DAC-1:0] code_o,
   output logic                    sat_o
);

   // Signed range limits of an N_DAC-bit code, carried at W bits
   localparam logic signed [W-1:0] MAXV = W'((1 << (N_DAC-1)) - 1);
   localparam logic signed [W-1:0] MINV = ~MAXV;

   logic signed [W-1:0]     s;
   logic        [N_DAC-1:0] clamped;

   always_comb begin
      s       = u_i >>> SHIFT;
      sat_o   = 1'b0;
      clamped = s[N_DAC-1:0];
      if (s > MAXV) begin
         clamped = MAXV[N_DAC-1:0];
         sat_o   = 1'b1;
      end else if (s < MINV) begin
         clamped = MINV[N_DAC-1:0];
         sat_o   = 1'b1;
      end
      code_o = {~clamped[N_DAC-1], clamped[N_DAC-2:0]};
   end

endmodule

// File: rtl/dac_spi_driver.sv
// SPI driver for the actuator DAC.
// Captures the controller word on Listo, converts it to a 12-bit offset
// binary code and sends one 16-bit {CMD, code} frame: CS setup, 16 bits of
// 2*CLK_DIV cycles each (DAC samples on SCLK rise), CS hold, then a CS-high
// gap. A Listo arriving while busy lands in a one-deep pending register
// (newest wins, Overrun flags an overwrite) and is sent as soon as the gap
// ends.
//   CLK     system clock, rising edge
//   Reset   synchronous, active-high
//   bus     slave side of dac_spi_driver_if (u/Listo in, SPI pins + status out)
module dac_spi_driver
   import pd_pkg::*;
#(
   parameter int         W       = PD_W,
   parameter int         SHIFT   = 4,
   parameter int         N_DAC   = 12,
   parameter int         CLK_DIV = 4,
   parameter logic [3:0] CMD     = CMD_DEFAULT
) (
   input logic             CLK,
   input logic             Reset,
   dac_spi_driver_if.slave bus
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(FRAME_W);

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [FRAME_W-1:0]   sr_q, sr_d;
   logic                 sclk_q, sclk_d;
   logic                 cs_n_q, cs_n_d;
   logic                 hecho_q, hecho_d;
   logic                 sat_q, sat_d;
   logic signed [W-1:0]  pend_q, pend_d;
   logic                 pvld_q, pvld_d;
   logic                 ovr_q, ovr_d;

   logic                 tick_end;
   logic                 ready;
   logic                 load;
   logic signed [W-1:0]  conv_src;
   logic [N_DAC-1:0]     code_w;
   logic                 sat_w;
   logic [FRAME_W-1:0]   frame_w;

   // A held sample always has priority over a fresh strobe at load time
   assign conv_src = pvld_q ? pend_q : bus.u;

   saturador_dac #(
      .W     (W),
      .SHIFT (SHIFT),
      .N_DAC (N_DAC)
   ) u_sat (
      .u_i    (conv_src),
      .code_o (code_w),
      .sat_o  (sat_w)
   );

   assign frame_w  = {CMD, code_w};
   assign tick_end = (cnt_q == CW'(CLK_DIV - 1));
   // The GAP exit edge behaves like IDLE so a queued sample starts back-to-back
   assign ready    = (state_q == S_IDLE) || ((state_q == S_GAP) && tick_end);
   assign load     = ready && (pvld_q || bus.Listo);

   always_comb begin
      state_d = state_q;
      cnt_d   = tick_end ? '0 : cnt_q + 1'b1;
      bit_d   = bit_q;
      sr_d    = sr_q;
      sclk_d  = sclk_q;
      cs_n_d  = cs_n_q;
      hecho_d = 1'b0;
      sat_d   = sat_q;
      pend_d  = pend_q;
      pvld_d  = pvld_q;
      ovr_d   = ovr_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
         end
         S_SETUP: begin
            if (tick_end) state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (tick_end) begin
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  // MOSI only moves on the SCLK fall, half a bit after sampling
                  sclk_d = 1'b0;
                  if (bit_q == BW'(FRAME_W - 1)) begin
                     state_d = S_HOLD;
                  end else begin
                     sr_d  = sr_q << 1;
                     bit_d = bit_q + 1'b1;
                  end
               end
            end
         end
         S_HOLD: begin
            if (tick_end) begin
               state_d = S_GAP;
               cs_n_d  = 1'b1;
               hecho_d = 1'b1;
            end
         end
         S_GAP: begin
            if (tick_end) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (load) begin
         state_d = S_SETUP;
         cnt_d   = '0;
         bit_d   = '0;
         sr_d    = frame_w;
         sclk_d  = 1'b0;
         cs_n_d  = 1'b0;
         sat_d   = sat_w;
      end

      // Pending register: a strobe is held unless it is being sent directly
      if (bus.Listo && !(load && !pvld_q)) begin
         pend_d = bus.u;
         pvld_d = 1'b1;
         if (pvld_q && !load) ovr_d = 1'b1;
      end else if (load) begin
         pvld_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sr_q    <= '0;
         sclk_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         hecho_q <= 1'b0;
         sat_q   <= 1'b0;
         pend_q  <= '0;
         pvld_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sr_q    <= sr_d;
         sclk_q  <= sclk_d;
         cs_n_q  <= cs_n_d;
         hecho_q <= hecho_d;
         sat_q   <= sat_d;
         pend_q  <= pend_d;
         pvld_q  <= pvld_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bus.SCLK    = sclk_q;
   assign bus.MOSI    = cs_n_q ? 1'b0 : sr_q[FRAME_W-1];
   assign bus.CS_n    = cs_n_q;
   assign bus.Busy    = (state_q != S_IDLE);
   assign bus.Hecho   = hecho_q;
   assign bus.Sat     = sat_q;
   assign bus.Overrun = ovr_q;

endmodule

// File: tb/tb_dac_spi_driver.sv
// Bench for dac_spi_driver: table of conversion vectors, hand sequences for
// overrun and mid-frame reset, and random strobes against a timeline model.
module tb_dac_spi_driver;
   import pd_pkg::*;

   localparam int K      = 4;
   localparam int CS_LOW = 34 * K;
   localparam int PERIOD = 35 * K;

   logic CLK   = 1'b0;
   logic Reset = 1'b1;

   dac_spi_driver_if #(.W(PD_W)) bus ();

   dac_spi_driver #(
      .W       (PD_W),
      .SHIFT   (4),
      .N_DAC   (12),
      .CLK_DIV (K),
      .CMD     (4'b0011)
   ) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          start;
      logic [15:0] frame;
      logic        sat;
   } exp_t;

   typedef struct {
      logic [18:0] u;
      logic [15:0] frame;
      logic        sat;
   } vec_t;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // reference model state
   exp_t        q[$];
   int          m_free_at = 0;
   logic [18:0] m_pend    = '0;
   logic        m_pvld    = 1'b0;
   logic        m_ovr     = 1'b0;
   logic        m_sat     = 1'b0;

   // monitor state
   logic        in_frame   = 1'b0;
   logic        f_abort    = 1'b0;
   exp_t        f_exp;
   int          f_bits     = 0;
   logic [15:0] f_shift    = '0;
   logic        prev_cs    = 1'b1;
   logic        prev_sclk  = 1'b0;
   logic [31:0] last_frame = 32'hDEAD;
   logic        last_sat   = 1'b0;
   int          last_start = -1;
   int          nframes    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Spec-level conversion: floor(u/16), clamp to 12-bit signed, add 2048
   task automatic ref_conv(input logic [18:0] uv, output logic [15:0] fr, output logic st);
      int sx, s;
      sx = $signed(uv);
      if (sx < 0) s = -((-sx + 15) / 16);
      else        s = sx / 16;
      st = 1'b0;
      if (s > 2047)  begin s = 2047;  st = 1'b1; end
      if (s < -2048) begin s = -2048; st = 1'b1; end
      fr = 16'(32'h3000 + s + 2048);
   endtask

   // Model the effect of the upcoming rising edge p = cyc+1
   task automatic model_edge(input logic rst, input logic listo, input logic [18:0] uv);
      int          p;
      logic [18:0] w;
      logic [15:0] fr;
      logic        st;
      p = cyc + 1;
      if (rst) begin
         m_pvld    = 1'b0;
         m_ovr     = 1'b0;
         m_sat     = 1'b0;
         m_free_at = p;
         q.delete();
         if (in_frame) f_abort = 1'b1;
         return;
      end
      if (p >= m_free_at && (m_pvld || listo)) begin
         w = m_pvld ? m_pend : uv;
         ref_conv(w, fr, st);
         q.push_back('{p, fr, st});
         m_sat     = st;
         m_free_at = p + PERIOD;
         if (m_pvld && listo) m_pend = uv;
         else                 m_pvld = 1'b0;
      end else if (listo) begin
         if (m_pvld) m_ovr = 1'b1;
         m_pend = uv;
         m_pvld = 1'b1;
      end
   endtask

   task automatic monitor();
      logic exp_hecho;
      chk("busy", bus.Busy, cyc < m_free_at);
      chk("overrun", bus.Overrun, m_ovr);
      chk("sat", bus.Sat, m_sat);
      exp_hecho = in_frame && !f_abort && (cyc == f_exp.start + CS_LOW);
      chk("hecho", bus.Hecho, exp_hecho);
      if (bus.CS_n) chk("sclk_idle", bus.SCLK, 1'b0);
      if (prev_cs && !bus.CS_n) begin
         if (q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
         end else begin
            f_exp = q.pop_front();
            chk("frame_start", cyc, f_exp.start);
            chk("mosi_first", bus.MOSI, f_exp.frame[15]);
         end
         in_frame = 1'b1;
         f_abort  = 1'b0;
         f_bits   = 0;
         f_shift  = '0;
      end
      if (in_frame && !bus.CS_n && bus.SCLK && !prev_sclk) begin
         f_shift = {f_shift[14:0], bus.MOSI};
         f_bits++;
      end
      if (in_frame && !prev_cs && bus.CS_n) begin
         if (!f_abort) begin
            chk("frame_bits", f_bits, 16);
            chk("frame_data", f_shift, f_exp.frame);
            chk("cs_low_len", cyc - f_exp.start, CS_LOW);
            last_frame = {16'h0, f_shift};
            last_sat   = bus.Sat;
            last_start = f_exp.start;
            nframes++;
         end
         in_frame = 1'b0;
         f_abort  = 1'b0;
      end
      prev_cs   = bus.CS_n;
      prev_sclk = bus.SCLK;
   endtask

   // Drive inputs for the next rising edge, then sample on the falling edge
   task automatic tick(input logic rst, input logic listo, input logic [18:0] uv);
      Reset     = rst;
      bus.Listo = listo;
      bus.u     = uv;
      model_edge(rst, listo, uv);
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
      monitor();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0);
   endtask

   vec_t vt[11];

   initial begin
      int p0, p1, p2, nf0;
      bus.u     = '0;
      bus.Listo = 1'b0;

      vt[0]  = '{19'h00000, 16'h3800, 1'b0};
      vt[1]  = '{19'h00100, 16'h3810, 1'b0};
      vt[2]  = '{19'h7FFF0, 16'h37FF, 1'b0};
      vt[3]  = '{19'h3FFFF, 16'h3FFF, 1'b1};
      vt[4]  = '{19'h40000, 16'h3000, 1'b1};
      vt[5]  = '{19'h00200, 16'h3820, 1'b0};
      vt[6]  = '{19'h7FFFF, 16'h37FF, 1'b0};
      vt[7]  = '{19'h08000, 16'h3FFF, 1'b1};
      vt[8]  = '{19'h07FF0, 16'h3FFF, 1'b0};
      vt[9]  = '{19'h78000, 16'h3000, 1'b0};
      vt[10] = '{19'h77FF0, 16'h3000, 1'b1};

      @(negedge CLK);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0);
      chk("rst_cs_n", bus.CS_n, 1'b1);
      chk("rst_sclk", bus.SCLK, 1'b0);
      chk("rst_mosi", bus.MOSI, 1'b0);
      chk("rst_busy", bus.Busy, 1'b0);
      chk("rst_hecho", bus.Hecho, 1'b0);
      chk("rst_sat", bus.Sat, 1'b0);
      chk("rst_ovr", bus.Overrun, 1'b0);

      // conversion table
      for (int i = 0; i < 11; i++) begin
         last_frame = 32'hDEAD;
         tick(1'b0, 1'b1, vt[i].u);
         p0 = cyc;
         idle(PERIOD + 2);
         chk("vec_frame", last_frame, {16'h0, vt[i].frame});
         chk("vec_sat", last_sat, vt[i].sat);
         chk("vec_start", last_start, p0);
      end

      // overrun: strobes at capture+10 and +20 while the first frame runs
      nf0 = nframes;
      tick(1'b0, 1'b1, 19'h00000);
      p0 = cyc;
      while (cyc < p0 + 9) idle(1);
      tick(1'b0, 1'b1, 19'h00100);
      chk("ovr_not_yet", bus.Overrun, 1'b0);
      while (cyc < p0 + 19) idle(1);
      tick(1'b0, 1'b1, 19'h00200);
      chk("ovr_set", bus.Overrun, 1'b1);
      while (cyc < p0 + 140 + CS_LOW + 6) idle(1);
      chk("ovr_frame", last_frame, 32'h3820);
      chk("ovr_start", last_start, p0 + 140);
      chk("ovr_count", nframes - nf0, 2);
      chk("ovr_sticky", bus.Overrun, 1'b1);

      // reset in the middle of a frame
      tick(1'b1, 1'b0, '0);
      chk("rst_clr_ovr", bus.Overrun, 1'b0);
      nf0        = nframes;
      last_frame = 32'hDEAD;
      tick(1'b0, 1'b1, 19'h00100);
      p1 = cyc;
      while (cyc < p1 + 49) idle(1);
      tick(1'b1, 1'b0, '0);
      chk("abort_cs_n", bus.CS_n, 1'b1);
      chk("abort_sclk", bus.SCLK, 1'b0);
      chk("abort_busy", bus.Busy, 1'b0);
      chk("abort_hecho", bus.Hecho, 1'b0);
      idle(200);
      chk("abort_no_frame", nframes - nf0, 0);
      tick(1'b0, 1'b1, 19'h00200);
      p2 = cyc;
      idle(PERIOD + 2);
      chk("after_abort_frame", last_frame, 32'h3820);
      chk("after_abort_start", last_start, p2);

      // random strobes against the model
      tick(1'b1, 1'b0, '0);
      for (int i = 0; i < 4000; i++) begin
         logic        l;
         logic [18:0] uv;
         int          v;
         l = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 1) == 0) begin
            v  = int'($urandom_range(0, 70000)) - 35000;
            uv = 19'(v);
         end else begin
            uv = 19'($urandom);
         end
         tick(1'b0, l, uv);
      end
      idle(2 * PERIOD + 4);
      chk("queue_empty", q.size(), 0);
      chk("no_open_frame", in_frame, 1'b0);
      chk("final_idle", bus.Busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
